// File: rtl/patch_embed_stream.sv
// patch_embed_stream: buffers one patch, projects it to E dims with LANES signed MACs, adds bias/pos, saturates
module patch_embed_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int IMG_H = 224,
  parameter int IMG_W = 224,
  parameter int C = 3,
  parameter int PH = 16,
  parameter int PW = 16,
  parameter int E = 128,
  parameter int LANES = 4,
  parameter int ADD_POS = 0,
  localparam int DW = DATA_WIDTH,
  localparam int PATCH_SIZE = PH * PW * C,
  localparam int NUM_PATCHES = (IMG_H / PH) * (IMG_W / PW)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  input  logic [DW-1:0]                   pix_data,
  input  logic [DW*PATCH_SIZE*E-1:0]      w_in,
  input  logic [DW*E-1:0]                 b_in,
  input  logic [DW*NUM_PATCHES*E-1:0]     pos_in,
  output logic                            tok_valid,
  input  logic                            tok_ready,
  output logic [DW-1:0]                   tok_data,
  output logic                            tok_last,
  output logic                            done,
  output logic [15:0]                     sat_count
);
  localparam int ACC_W = 2 * DW + $clog2(PATCH_SIZE) + 2;
  localparam int KW = $clog2(PATCH_SIZE + 1);
  localparam int EW = $clog2(E + 1);
  localparam int PIW = $clog2(NUM_PATCHES + 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, FILL, MAC, ROUND, EMIT, DONE} state_t;
  state_t state, state_n;
  logic signed [DW-1:0] pix_buf [PATCH_SIZE];
  logic [KW-1:0] k;
  logic [EW-1:0] e, e_ld;
  logic [PIW-1:0] p;
  logic signed [ACC_W-1:0] acc, mac_sum, acc_ld;
  logic signed [DW-1:0] w_l [LANES];
  logic signed [2*DW-1:0] prod [LANES];
  logic signed [DW-1:0] b_sel, pos_add;
  logic signed [ACC_W:0] r_full;
  logic last_k, last_grp, last_e, last_p, clip;
  assign last_k = k == KW'(PATCH_SIZE - 1);
  assign last_grp = k == KW'(PATCH_SIZE - LANES);
  assign last_e = e == EW'(E - 1);
  assign last_p = p == PIW'(NUM_PATCHES - 1);
  assign pix_ready = state == FILL;
  assign tok_valid = state == EMIT;
  assign tok_last = tok_valid && last_e;
  assign done = state == DONE;
  always_comb begin
    mac_sum = acc;
    for (int l = 0; l < LANES; l++) begin
      w_l[l] = w_in[(((int'(k) + l) % PATCH_SIZE) * E + int'(e)) * DW +: DW];
      prod[l] = pix_buf[(int'(k) + l) % PATCH_SIZE] * w_l[l];
      mac_sum = mac_sum + prod[l];
    end
    e_ld = (state == EMIT && !last_e) ? e + EW'(1) : '0;
    b_sel = b_in[int'(e_ld) * DW +: DW];
    acc_ld = ACC_W'(b_sel) <<< FRAC_BITS;
    pos_add = ADD_POS != 0 ? pos_in[(int'(p) * E + int'(e)) * DW +: DW] : '0;
    // widened by one bit so the positional add cannot wrap before saturation
    r_full = (acc >>> FRAC_BITS) + pos_add;
    clip = r_full > MAXV || r_full < MINV;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FILL : IDLE;
      FILL:    state_n = (pix_valid && last_k) ? MAC : FILL;
      MAC:     state_n = last_grp ? ROUND : MAC;
      ROUND:   state_n = EMIT;
      EMIT:    state_n = !tok_ready ? EMIT : !last_e ? MAC : !last_p ? FILL : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (state == FILL && pix_valid) pix_buf[k] <= pix_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      e <= '0;
      p <= '0;
      acc <= '0;
      tok_data <= '0;
      sat_count <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          k <= '0;
          p <= '0;
          sat_count <= '0;
        end
        FILL: if (pix_valid) begin
          k <= last_k ? '0 : k + KW'(1);
          if (last_k) begin
            e <= '0;
            acc <= acc_ld;
          end
        end
        MAC: begin
          acc <= mac_sum;
          k <= last_grp ? '0 : k + KW'(LANES);
        end
        ROUND: begin
          tok_data <= r_full > MAXV ? {1'b0, {(DW-1){1'b1}}} : r_full < MINV ? {1'b1, {(DW-1){1'b0}}} : r_full[DW-1:0];
          sat_count <= sat_count + 16'(clip && sat_count != 16'hFFFF);
        end
        EMIT: if (tok_ready) begin
          if (!last_e) begin
            e <= e_ld;
            acc <= acc_ld;
          end else if (!last_p) p <= p + PIW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_patch_embed_stream.sv
// tb_patch_embed_stream: random and directed frames checked against an arithmetic patch-embedding model
module tb_patch_embed_stream;
  localparam int DW = 16, PS = 4, NP = 4, E = 2, LANES_T = 2, ADD_POS_T = 1;
  logic clk = 0, rst = 1, start = 0, pix_valid = 0, tok_ready = 0;
  logic [DW-1:0] pix_data = '0;
  logic [DW*PS*E-1:0] w_in;
  logic [DW*E-1:0] b_in;
  logic [DW*NP*E-1:0] pos_in;
  logic pix_ready, tok_valid, tok_last, done;
  logic [DW-1:0] tok_data;
  logic [15:0] sat_count;
  logic signed [15:0] px [NP*PS];
  logic signed [15:0] wv [PS][E];
  logic signed [15:0] bv [E];
  logic signed [15:0] pv [NP][E];
  logic [15:0] exp_q [$];
  int exp_sat;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  patch_embed_stream #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_H(4), .IMG_W(4), .C(1), .PH(2), .PW(2),
    .E(E), .LANES(LANES_T), .ADD_POS(ADD_POS_T)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .w_in(w_in), .b_in(b_in), .pos_in(pos_in), .tok_valid(tok_valid),
    .tok_ready(tok_ready), .tok_data(tok_data), .tok_last(tok_last), .done(done), .sat_count(sat_count));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  task automatic pack_and_model();
    longint acc, r;
    exp_q.delete();
    exp_sat = 0;
    for (int e = 0; e < E; e++) begin
      b_in[e*DW +: DW] = bv[e];
      for (int k = 0; k < PS; k++) w_in[(k*E+e)*DW +: DW] = wv[k][e];
      for (int p = 0; p < NP; p++) pos_in[(p*E+e)*DW +: DW] = pv[p][e];
    end
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < E; e++) begin
        acc = longint'(bv[e]) * 256;
        for (int k = 0; k < PS; k++) acc += longint'(px[p*PS+k]) * longint'(wv[k][e]);
        r = acc >>> 8;
        if (ADD_POS_T != 0) r += longint'(pv[p][e]);
        if (r > 32767) begin r = 32767; exp_sat++; end
        else if (r < -32768) begin r = -32768; exp_sat++; end
        exp_q.push_back(16'(r));
      end
  endtask
  task automatic set_const(input logic [15:0] pval, input logic [15:0] wval, input logic [15:0] bval, input bit pos_ramp);
    for (int i = 0; i < NP*PS; i++) px[i] = pval;
    for (int e = 0; e < E; e++) begin
      bv[e] = bval;
      for (int k = 0; k < PS; k++) wv[k][e] = wval;
      for (int p = 0; p < NP; p++) pv[p][e] = pos_ramp ? 16'(p*16 + e) : 16'h0;
    end
  endtask
  task automatic set_rand(input bit big);
    for (int i = 0; i < NP*PS; i++) px[i] = big ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
    for (int e = 0; e < E; e++) begin
      bv[e] = big ? 16'($urandom) : 16'($urandom_range(0, 4095)) - 16'd2048;
      for (int k = 0; k < PS; k++) wv[k][e] = big ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      for (int p = 0; p < NP; p++) pv[p][e] = big ? 16'($urandom) : 16'($urandom_range(0, 255)) - 16'd128;
    end
  endtask
  task automatic check_reset();
    check("rst_pix_ready", pix_ready, 0);
    check("rst_tok_valid", tok_valid, 0);
    check("rst_tok_last", tok_last, 0);
    check("rst_done", done, 0);
    check("rst_tok_data", tok_data, 0);
    check("rst_sat_count", sat_count, 0);
  endtask
  task automatic run_frame(input bit stall, input bit gap, input bit hold_start);
    int pi = 0, ti = 0, cyc = 0, last_acc = -100;
    bit fin = 0, held = 0;
    logic [15:0] hd;
    logic hl;
    pack_and_model();
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      start = (cyc == 0) || hold_start;
      if (done) begin
        check("done_after_last", cyc - last_acc, 1);
        check("tok_count", ti, NP*E);
        check("sat_count", sat_count, exp_sat);
        start = 0;
        fin = 1;
      end
      if (tok_valid) check("pix_ready_in_emit", pix_ready, 0);
      if (held && tok_valid) begin
        check("stall_data", tok_data, hd);
        check("stall_last", tok_last, hl);
      end
      held = 0;
      tok_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (tok_valid && tok_ready) begin
        if (ti < NP*E) begin
          check("tok_data", tok_data, exp_q[ti]);
          check("tok_last", tok_last, ti % E == E - 1);
          if (!stall && ti % E != 0) check("elem_spacing", cyc - last_acc, PS/LANES_T + 2);
        end else check("extra_token", ti, NP*E - 1);
        last_acc = cyc;
        ti++;
      end else if (tok_valid) begin
        held = 1;
        hd = tok_data;
        hl = tok_last;
      end
      if (pi < NP*PS) begin
        pix_valid = gap ? cyc[0] : 1'b1;
        pix_data = px[pi];
        if (pix_valid && pix_ready) pi++;
      end else pix_valid = 0;
      cyc++;
    end
    check("frame_finished", fin, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    pix_valid = 0;
  endtask
  task automatic abort_frame();
    int pi = 0, cyc = 0;
    pack_and_model();
    while (pi < PS + 3 && cyc < 2000) begin
      @(negedge clk);
      start = 1;
      tok_ready = 1;
      pix_valid = 1;
      pix_data = px[pi];
      if (pix_ready) pi++;
      cyc++;
    end
    check("abort_reached", pi, PS + 3);
    @(negedge clk);
    start = 0;
    pix_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset();
  endtask
  initial begin
    set_const(16'h0100, 16'h0100, 16'h0, 0);
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    run_frame(0, 0, 0);
    set_const(16'h7FFF, 16'h7FFF, 16'h0, 0);
    run_frame(0, 0, 0);
    set_const(16'h7FFF, 16'h8001, 16'h0, 0);
    run_frame(0, 0, 0);
    set_const(16'h0, 16'h0, 16'h0100, 1);
    run_frame(0, 0, 0);
    set_const(16'h0100, 16'h0100, 16'h0, 0);
    run_frame(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      set_rand(i >= 4);
      run_frame(i[0], i[1], 0);
    end
    set_const(16'h7FFF, 16'h7FFF, 16'h0, 0);
    abort_frame();
    set_rand(0);
    run_frame(0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
